wb_arbiter_2to1: RTL and testbench
==================================

// Module: wb_arbiter_2to1
// PURPOSE
//  Two-master, one-slave Wishbone B4 classic bus arbiter between the RISC-V core and the shared
//  memory. Master 0 = instruction fetch, master 1 = load/store. Fair round-robin, bus held for
//  the whole CYC tenure. A watchdog terminates slave cycles that never ACK.
// PARAMETERS
//  AW       32  address width (byte address)
//  DW       32  data width; SEL width = DW/8
//  TIMEOUT  255 cycles of STB without ACK/ERR before forced error; 0 disables watchdog
// PORTS  (N = 0,1; one port set per master)
//  i_clk        in   1      clock, all state on rising edge
//  i_reset_n    in   1      asynchronous, active-low reset
//  i_mN_cyc     in   1      master N bus cycle request
//  i_mN_stb     in   1      master N strobe
//  i_mN_we      in   1      master N write enable
//  i_mN_adr     in   AW     master N address
//  i_mN_dat     in   DW     master N write data
//  i_mN_sel     in   DW/8   master N byte selects
//  o_mN_dat     out  DW     read data to master N (i_s_dat, unregistered)
//  o_mN_ack     out  1      ack to master N
//  o_mN_err     out  1      error to master N (slave ERR or watchdog)
//  o_s_cyc/o_s_stb/o_s_we  out 1   slave cycle/strobe/write
//  o_s_adr      out  AW     slave address
//  o_s_dat      out  DW     slave write data
//  o_s_sel      out  DW/8   slave byte selects
//  i_s_dat      in   DW     slave read data
//  i_s_ack      in   1      slave ack
//  i_s_err      in   1      slave error
//  o_grant      out  2      one-hot current owner (debug/perf)
// BEHAVIOUR
//  - State reg: IDLE, OWN0, OWN1. Pointer `last` = last owner; reset: IDLE, last=1 (m0 wins 1st tie).
//  - Reset (async, any time incl. mid-transfer): IDLE, wdog=0; o_s_cyc/stb, all ack/err, o_grant
//    go 0 immediately. Data/address outputs 0 while IDLE.
//  - IDLE: one cyc -> own it next edge; both -> the one != last. Grant latency: master raises cyc
//    in cycle N, o_s_cyc=1 in cycle N+1. No combinational grant path.
//  - OWNn: o_s_* = master n inputs (combinational mux from state). o_s_cyc = i_mn_cyc.
//    o_mn_ack = i_s_ack, o_mn_err = i_s_err | wdog_err. Non-owner ack/err forced 0; both
//    o_mN_dat = i_s_dat.
//  - Release: owner cyc=0 at edge -> other master cyc=1 ? OWN(other) : IDLE; last=n. Handover with
//    no dead cycle; a non-owner never preempts, even across many owner transfers (B4 pipelined
//    bursts under one CYC allowed).
//  - Slave ack/err arriving with o_s_cyc=0 is ignored (not forwarded).
//  - Watchdog: 8-bit-min counter (clog2(TIMEOUT+1)), clears on ack/err, stb=0 or ownership
//    change; increments while owner stb=1. When count==TIMEOUT, o_mn_err=1 for exactly that
//    cycle, counter clears, o_s_stb masked to 0 that cycle. Ownership kept until master drops cyc.
//  - Simultaneous i_s_ack and watchdog expiry: ack forwarded, err suppressed.
//  - ack and err never both asserted to a master; if slave drives both, err wins.
// TESTING
//  - Reset: i_reset_n=0 mid OWN1 write -> same-cycle o_s_cyc=0, o_grant=00; after release m0
//    req granted 1 cycle later.
//  - Single master: m0 cyc/stb read adr=0x100, slave acks 2 cycles later with 0xDEADBEEF ->
//    o_m0_ack 1 cycle, o_m0_dat=0xDEADBEEF, o_m1_ack=0.
//  - Contention: m0,m1 raise cyc same cycle after reset -> m0 first; m0 drops cyc -> OWN1 next
//    cycle, no idle; repeat -> alternates 0,1,0,1.
//  - No preemption: m1 holds cyc for 4-beat burst while m0 requests -> m0 waits until m1 cyc=0.
//  - Watchdog: TIMEOUT=4, slave never acks -> o_m0_err high exactly 4 cycles after stb, stb masked
//    that cycle; ack in expiry cycle -> ack only.
//  - Stray slave ack in IDLE -> no master sees ack/err.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// Two-master / one-slave Wishbone B4 classic arbiter.
// Master 0 is instruction fetch, master 1 is load/store. Round-robin on ties,
// the owner keeps the bus for its whole CYC tenure, and a watchdog converts a
// slave that never answers into an error to the owning master.
module wb_arbiter_2to1 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [AW-1:0]     i_m0_adr,
    input  logic [DW-1:0]     i_m0_dat,
    input  logic [DW/8-1:0]   i_m0_sel,
    output logic [DW-1:0]     o_m0_dat,
    output logic              o_m0_ack,
    output logic              o_m0_err,

    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [AW-1:0]     i_m1_adr,
    input  logic [DW-1:0]     i_m1_dat,
    input  logic [DW/8-1:0]   i_m1_sel,
    output logic [DW-1:0]     o_m1_dat,
    output logic              o_m1_ack,
    output logic              o_m1_err,

    output logic              o_s_cyc,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [AW-1:0]     o_s_adr,
    output logic [DW-1:0]     o_s_dat,
    output logic [DW/8-1:0]   o_s_sel,
    input  logic [DW-1:0]     i_s_dat,
    input  logic              i_s_ack,
    input  logic              i_s_err,

    output logic [1:0]        o_grant
);

    localparam int unsigned SW      = DW / 8;
    localparam int unsigned TW_RAW  = $clog2(TIMEOUT + 1);
    localparam int unsigned WDW     = (TW_RAW > 8) ? TW_RAW : 8;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q,  last_d;
    logic [WDW-1:0]   wdog_q,  wdog_d;

    logic             own_cyc;
    logic             own_stb;
    logic             own_we;
    logic [AW-1:0]    own_adr;
    logic [DW-1:0]    own_dat;
    logic [SW-1:0]    own_sel;

    logic             s_ack_v;
    logic             s_err_v;
    logic             wdog_exp;
    logic             fwd_ack;
    logic             fwd_err;

    // Owner selection mux: slave-side signals come straight from the owning
    // master; everything is zero while nobody owns the bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            OWN0: begin
                own_cyc = i_m0_cyc;
                own_stb = i_m0_stb;
                own_we  = i_m0_we;
                own_adr = i_m0_adr;
                own_dat = i_m0_dat;
                own_sel = i_m0_sel;
            end
            OWN1: begin
                own_cyc = i_m1_cyc;
                own_stb = i_m1_stb;
                own_we  = i_m1_we;
                own_adr = i_m1_adr;
                own_dat = i_m1_dat;
                own_sel = i_m1_sel;
            end
            default: begin
                own_cyc = 1'b0;
            end
        endcase
    end

    // Slave responses only count while a cycle is actually open; the watchdog
    // fires on the cycle its count reaches the limit with the strobe still up.
    always_comb begin
        s_ack_v  = i_s_ack & own_cyc;
        s_err_v  = i_s_err & own_cyc;
        wdog_exp = (TIMEOUT != 0) && own_cyc && own_stb && (wdog_q == WD_LIMIT);
        // Slave ERR beats ACK; a genuine ACK beats a coincident watchdog expiry.
        fwd_ack  = s_ack_v & ~s_err_v;
        fwd_err  = s_err_v | (wdog_exp & ~s_ack_v);
    end

    // Ownership state: grant from IDLE by round-robin, hold until the owner
    // drops CYC, then hand straight to a waiting master with no idle cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (i_m0_cyc) begin
                    state_d = OWN0;
                end else if (i_m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    state_d = i_m1_cyc ? OWN1 : IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    state_d = i_m0_cyc ? OWN0 : IDLE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Watchdog count: advances only while the same owner keeps STB up without
    // any response; any answer, idle strobe, expiry or owner change restarts it.
    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if ((TIMEOUT == 0) || (state_q == IDLE) || (state_d != state_q) ||
            !own_stb || !own_cyc || s_ack_v || s_err_v || wdog_exp) begin
            wdog_d = '0;
        end
    end

    // State, round-robin pointer and watchdog registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Bus outputs: slave side from the owner mux, master responses gated to
    // the owner only, read data broadcast to both masters.
    always_comb begin
        o_s_cyc  = own_cyc;
        o_s_stb  = own_stb & ~wdog_exp;
        o_s_we   = own_we;
        o_s_adr  = own_adr;
        o_s_dat  = own_dat;
        o_s_sel  = own_sel;
        o_m0_dat = i_s_dat;
        o_m1_dat = i_s_dat;
        o_m0_ack = (state_q == OWN0) & fwd_ack;
        o_m0_err = (state_q == OWN0) & fwd_err;
        o_m1_ack = (state_q == OWN1) & fwd_ack;
        o_m1_err = (state_q == OWN1) & fwd_err;
        o_grant  = {state_q == OWN1, state_q == OWN0};
    end

`ifndef SYNTHESIS
    a_m0_ack_err_excl : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(o_m0_ack && o_m0_err));
    a_m1_ack_err_excl : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(o_m1_ack && o_m1_err));
    a_grant_onehot0   : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_grant));
    a_resp_one_master : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !((o_m0_ack || o_m0_err) && (o_m1_ack || o_m1_err)));
`endif

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 with a short watchdog (TIMEOUT=4).
module tb_wb_arbiter_2to1;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;

    logic            m0_cyc, m0_stb, m0_we;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_wdat;
    logic [3:0]      m0_sel;
    logic [DW-1:0]   m0_rdat;
    logic            m0_ack, m0_err;

    logic            m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_wdat;
    logic [3:0]      m1_sel;
    logic [DW-1:0]   m1_rdat;
    logic            m1_ack, m1_err;

    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic [3:0]      s_sel;
    logic [DW-1:0]   s_rdat;
    logic            s_ack, s_err;
    logic [1:0]      grant;

    int unsigned     n_assert = 0;
    int unsigned     n_fail   = 0;

    wb_arbiter_2to1 #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m0_cyc  (m0_cyc),
        .i_m0_stb  (m0_stb),
        .i_m0_we   (m0_we),
        .i_m0_adr  (m0_adr),
        .i_m0_dat  (m0_wdat),
        .i_m0_sel  (m0_sel),
        .o_m0_dat  (m0_rdat),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_cyc  (m1_cyc),
        .i_m1_stb  (m1_stb),
        .i_m1_we   (m1_we),
        .i_m1_adr  (m1_adr),
        .i_m1_dat  (m1_wdat),
        .i_m1_sel  (m1_sel),
        .o_m1_dat  (m1_rdat),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_s_cyc   (s_cyc),
        .o_s_stb   (s_stb),
        .o_s_we    (s_we),
        .o_s_adr   (s_adr),
        .o_s_dat   (s_wdat),
        .o_s_sel   (s_sel),
        .i_s_dat   (s_rdat),
        .i_s_ack   (s_ack),
        .i_s_err   (s_err),
        .o_grant   (grant)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
        s_rdat = '0; s_ack = 0; s_err = 0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_s_cyc", 64'(s_cyc), 64'd0);
        check_eq("rst_s_stb", 64'(s_stb), 64'd0);
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_acks",  64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        check_eq("rst_s_adr", 64'(s_adr), 64'd0);
        next_cycle;
        next_cycle;
        rst_n = 1'b1;

        // Single master read, slave answers two cycles after the grant
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hF;
        #1;
        check_eq("rd_no_comb_grant", 64'(grant), 64'd0);
        check_eq("rd_no_comb_cyc",   64'(s_cyc), 64'd0);
        next_cycle;
        check_eq("rd_grant", 64'(grant), 64'b01);
        check_eq("rd_s_cyc_stb", 64'({s_cyc, s_stb}), 64'b11);
        check_eq("rd_s_adr", 64'(s_adr), 64'h100);
        next_cycle;
        check_eq("rd_wait_ack", 64'(m0_ack), 64'd0);
        next_cycle;
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        #1;
        check_eq("rd_m0_ack", 64'(m0_ack), 64'd1);
        check_eq("rd_m0_dat", 64'(m0_rdat), 64'hDEADBEEF);
        check_eq("rd_m1_ack", 64'(m1_ack), 64'd0);
        check_eq("rd_m0_err", 64'(m0_err), 64'd0);
        next_cycle;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        check_eq("rd_ack_one_cycle", 64'(m0_ack), 64'd0);
        check_eq("rd_release_cyc", 64'(s_cyc), 64'd0);
        next_cycle;
        check_eq("rd_idle", 64'(grant), 64'd0);

        // Contention straight after reset: m0 first, then strict alternation
        rst_n = 1'b0;
        next_cycle;
        rst_n = 1'b1;
        m0_adr = 32'h200; m1_adr = 32'h300;
        m0_cyc = 1; m1_cyc = 1;
        next_cycle;
        check_eq("rr_first_m0", 64'(grant), 64'b01);
        check_eq("rr_adr_m0", 64'(s_adr), 64'h200);
        m0_cyc = 0;
        #1;
        check_eq("rr_drop_cyc", 64'(s_cyc), 64'd0);
        next_cycle;
        check_eq("rr_second_m1", 64'(grant), 64'b10);
        check_eq("rr_adr_m1", 64'(s_adr), 64'h300);
        check_eq("rr_m1_cyc", 64'(s_cyc), 64'd1);
        m0_cyc = 1; m1_cyc = 0;
        next_cycle;
        check_eq("rr_third_m0", 64'(grant), 64'b01);
        m0_cyc = 0; m1_cyc = 1;
        next_cycle;
        check_eq("rr_fourth_m1", 64'(grant), 64'b10);
        m1_cyc = 0;
        next_cycle;
        check_eq("rr_idle", 64'(grant), 64'd0);

        // No preemption: m1 runs a 4-beat pipelined burst while m0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h600; m1_wdat = 32'hA5A5_0000;
        next_cycle;
        m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1;
            m1_wdat = 32'hA5A5_0000 + 32'(i);
            #1;
            check_eq($sformatf("burst_grant_%0d", i), 64'(grant), 64'b10);
            check_eq($sformatf("burst_ack_%0d", i), 64'({m0_ack, m1_ack}), 64'b01);
            check_eq($sformatf("burst_wdat_%0d", i), 64'(s_wdat), 64'hA5A5_0000 + 64'(i));
            next_cycle;
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; m0_stb = 0;
        next_cycle;
        check_eq("burst_handover_m0", 64'(grant), 64'b01);

        // Tie with pointer pointing at m0 last -> m1 wins; slave ERR beats ACK
        m0_cyc = 0;
        next_cycle;
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1;
        next_cycle;
        check_eq("rr_tie_m1", 64'(grant), 64'b10);
        s_ack = 1; s_err = 1;
        #1;
        check_eq("both_resp_err", 64'({m1_ack, m1_err}), 64'b01);
        check_eq("both_resp_m0", 64'({m0_ack, m0_err}), 64'b00);
        next_cycle;
        s_ack = 0; s_err = 0; m1_cyc = 0; m1_stb = 0;
        next_cycle;
        check_eq("err_handover_m0", 64'(grant), 64'b01);
        m0_cyc = 0;
        next_cycle;

        // Stray slave response while idle
        s_ack = 1; s_err = 1;
        #1;
        check_eq("stray_resp", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        next_cycle;
        s_ack = 0; s_err = 0;

        // Watchdog: expiry four cycles into an unanswered strobe
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h500;
        next_cycle;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("wd_wait_%0d", k), 64'({m0_err, s_stb}), 64'b01);
            next_cycle;
        end
        #1;
        check_eq("wd_expire_err", 64'(m0_err), 64'd1);
        check_eq("wd_expire_stb", 64'(s_stb), 64'd0);
        check_eq("wd_expire_ack", 64'(m0_ack), 64'd0);
        check_eq("wd_keep_cyc", 64'(s_cyc), 64'd1);
        next_cycle;
        check_eq("wd_err_one_cycle", 64'({m0_err, s_stb}), 64'b01);
        check_eq("wd_keep_grant", 64'(grant), 64'b01);
        for (int k = 0; k < 4; k++) next_cycle;
        s_ack = 1;
        #1;
        check_eq("wd_ack_wins", 64'({m0_ack, m0_err}), 64'b10);
        next_cycle;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        next_cycle;
        check_eq("wd_idle", 64'(grant), 64'd0);

        // Async reset in the middle of an m1 write
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h400; m1_wdat = 32'h1234; m1_sel = 4'hF;
        next_cycle;
        check_eq("wr_grant_m1", 64'(grant), 64'b10);
        check_eq("wr_s_we", 64'(s_we), 64'd1);
        check_eq("wr_s_dat", 64'(s_wdat), 64'h1234);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_s_cyc", 64'(s_cyc), 64'd0);
        check_eq("midrst_grant", 64'(grant), 64'd0);
        check_eq("midrst_s_adr_we", 64'({s_adr, s_we}), 64'd0);
        next_cycle;
        rst_n = 1'b1;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        m0_cyc = 1;
        #1;
        check_eq("postrst_no_grant", 64'(grant), 64'd0);
        next_cycle;
        check_eq("postrst_grant_m0", 64'(grant), 64'b01);
        m0_cyc = 0;
        next_cycle;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
